// File: rtl/eight_bit_div.sv
// ============================================================================
// Module  : eight_bit_div
// Purpose : Sequential unsigned 8-bit restoring divider, one quotient bit per
//           cycle. Companion to the eight_bit_mul compressor multiplier.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module eight_bit_div (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  logic [7:0] r_q;
  logic [8:0] r_rem;
  logic [7:0] r_dvsr;
  logic [2:0] r_cnt;

  logic [8:0] w_shift;
  logic [8:0] w_diff;
  logic       w_ge;
  logic [8:0] w_rem_next;
  logic [7:0] w_q_next;

  // One restoring step: bring in the next dividend bit, try to subtract.
  assign w_shift    = {r_rem[7:0], r_q[7]};
  assign w_ge       = (w_shift >= {1'b0, r_dvsr});
  assign w_diff     = w_shift - {1'b0, r_dvsr};
  assign w_rem_next = w_ge ? w_diff : w_shift;
  assign w_q_next   = {r_q[6:0], w_ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_q         <= 8'd0;
      r_rem       <= 9'd0;
      r_dvsr      <= 8'd0;
      r_cnt       <= 3'd0;
      quotient    <= 8'd0;
      remainder   <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor == 8'd0) begin
              quotient    <= 8'hFF;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_q     <= dividend;
              r_dvsr  <= divisor;
              r_rem   <= 9'd0;
              r_cnt   <= 3'd0;
              busy    <= 1'b1;
              r_state <= S_CALC;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_q   <= w_q_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            quotient    <= w_q_next;
            remainder   <= w_rem_next[7:0];
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
